plic_claim_sequencer: RTL and testbench
=======================================

# plic_claim_sequencer

Hardware claim/complete agent for one PLIC target context. Watches that target's external-interrupt line. On assertion it reads the context's claim/complete register over the register bus and hands the claimed source ID to a hardware consumer (DMA engine, accelerator) over a valid/ready handshake. When the consumer signals done, it writes the ID back to complete the interrupt. It sits beside the PLIC on the same register interface, in place of a software hart servicing that context.

## Interface
- `CC_ADDR`, default 32'h0020_0004: byte address of this target's claim/complete register.
- `SRCW`, default 5: source ID width; must match the PLIC `SRCW`.
- `HOLDOFF`, default 4: idle cycles after a complete before `eip_i` is sampled again. Legal range 1–255.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: allows new claims; sampled only in IDLE.
- `eip_i`, in, 1: external-interrupt-pending from the PLIC for this target.
- `req_o`, out, `reg_intf_pkg::req_a32_d32`: register bus request; fields addr, write, wdata, wstrb, valid.
- `resp_i`, in, `reg_intf_pkg::rsp_d32`: register bus response; fields rdata, error, ready.
- `id_valid_o`, out, 1: a claimed ID is offered.
- `id_o`, out, SRCW: claimed source ID; nonzero whenever `id_valid_o` is high.
- `id_ready_i`, in, 1: consumer accepts the ID.
- `done_i`, in, 1: one-cycle pulse; consumer has finished servicing.
- `busy_o`, out, 1: high in any state other than IDLE.
- `bus_err_o`, out, 1: sticky; set on any `resp_i.error`. Cleared only by reset.
- `spurious_cnt_o`, out, 16: count of claims that returned ID 0; saturates at 16'hFFFF.

## Operation
- **FSM states:** IDLE, CLAIM, DELIVER, SERVICE, COMPLETE, HOLD.
- **IDLE:**
  - Goes to CLAIM when `enable_i && eip_i`.
  - Otherwise stays in IDLE.
- **CLAIM (bus read):**
  - Drives `req_o.valid=1`, write=0, addr=`CC_ADDR`, wstrb=4'h0, wdata=0.
  - On `resp_i.ready` with error: set `bus_err_o`, go to HOLD.
  - On `resp_i.ready` with `rdata[SRCW-1:0]==0`: increment `spurious_cnt_o`, go to HOLD.
  - On `resp_i.ready` with a nonzero ID: latch `rdata[SRCW-1:0]` into the ID register, go to DELIVER.
  - `rdata` bits above SRCW are ignored.
- **DELIVER:**
  - `id_valid_o=1`, `id_o` = latched ID.
  - Goes to SERVICE on `id_ready_i`.
- **SERVICE:**
  - Waits for `done_i`, then goes to COMPLETE.
  - `done_i` in any other state is ignored and not remembered.
- **COMPLETE (bus write):**
  - Drives valid=1, write=1, addr=`CC_ADDR`, wstrb=4'hF, wdata = latched ID zero-extended to 32 bits.
  - On `resp_i.ready`: set `bus_err_o` if error, then go to HOLD.
  - No retry on error in either CLAIM or COMPLETE.
- **HOLD:**
  - Loads a counter with `HOLDOFF-1` on entry and decrements it each cycle.
  - Goes to IDLE in the cycle the counter reads 0.
  - Purpose: absorbs the PLIC target's registered `eip_i` latency, so a stale `eip_i` does not trigger a re-claim.
- **Bus request hold rule:** while `req_o.valid && !resp_i.ready`, every `req_o` field stays stable. `valid` never drops before ready.
- **`enable_i` low:** affects only the IDLE→CLAIM decision. An in-flight sequence always runs through to HOLD.
- **Reset mid-operation:** the FSM returns to IDLE and no complete is issued. The gateway for that source stays claimed until software completes it. This is a documented limitation.

## Timing
- **Reset values:**
  - `req_o` all zero.
  - `id_valid_o`, `id_o`, `busy_o`, `bus_err_o` all 0.
  - `spurious_cnt_o` = 0.
  - State = IDLE.
- **Output registration:** all outputs are registered (driven from FSM state and registers). No combinational path from any input to any output.
- **Claim issue:** `eip_i` high in IDLE at edge N gives `req_o.valid` high after edge N (visible in cycle N+1).
- **Zero-wait bus:** with `resp_i.ready` returned in the same cycle as valid, a claim occupies exactly 1 cycle.
  - `id_valid_o` rises in the cycle after the read handshake.
  - `id_ready_i` high together with `id_valid_o` means SERVICE starts the next cycle.
  - COMPLETE begins the cycle after `done_i` is sampled.
- **Minimum cycle** (zero-wait bus, consumer ready and done immediately), IDLE to IDLE: 1 IDLE + 1 CLAIM + 1 DELIVER + 1 SERVICE + 1 COMPLETE + `HOLDOFF` HOLD.
- **`spurious_cnt_o` update:** changes one cycle after the read handshake.

## Test plan
- **Basic sequence:**
  - Stimulus: `eip_i`=1, bus returns rdata=3 with zero wait, consumer ready, `done_i` 2 cycles later.
  - Required: `id_o`=3 delivered; one write of wdata=3 to `CC_ADDR`; `busy_o` low after HOLDOFF=4 cycles.
- **Bus backpressure:**
  - Stimulus: `resp_i.ready` held low 5 cycles on both the read and the write.
  - Required: `req_o` fields stable throughout; exactly one read and one write complete.
- **Spurious claim:**
  - Stimulus: read returns 0.
  - Required: `spurious_cnt_o` 0→1, `id_valid_o` never asserts, no write issued.
  - Also: force the counter to 16'hFFFF and repeat; it stays at 16'hFFFF.
- **Bus error:**
  - Stimulus: `resp_i.error`=1 on the claim read.
  - Required: `bus_err_o`=1 sticky, no delivery, return to IDLE.
- **Consumer stall and stray done:**
  - Stimulus: `id_ready_i` low 10 cycles; `done_i` pulsed during DELIVER.
  - Required: `id_o` stable; the stray pulse is ignored; COMPLETE only after a `done_i` sampled in SERVICE.
- **Control and reset:**
  - `enable_i`=0 with `eip_i`=1: no claim.
  - `rst_ni` asserted during SERVICE: all outputs return to reset values immediately, and no write occurs.

Source files
------------

// File: rtl/reg_intf_pkg.sv
// Register bus request/response types shared by the PLIC and its bus agents.
package reg_intf_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } req_a32_d32;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } rsp_d32;

endpackage

// File: rtl/plic_claim_sequencer.sv
// Hardware claim/complete agent for one PLIC target context: claims on eip,
// hands the ID to a consumer, and writes it back once the consumer is done.
module plic_claim_sequencer #(
   parameter logic [31:0] CC_ADDR = 32'h0020_0004,
   parameter int unsigned SRCW    = 5,
   parameter int unsigned HOLDOFF = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enable_i,
   input  logic                     eip_i,
   output reg_intf_pkg::req_a32_d32 req_o,
   input  reg_intf_pkg::rsp_d32     resp_i,
   output logic                     id_valid_o,
   output logic [SRCW-1:0]          id_o,
   input  logic                     id_ready_i,
   input  logic                     done_i,
   output logic                     busy_o,
   output logic                     bus_err_o,
   output logic [15:0]              spurious_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLAIM,
      S_DELIVER,
      S_SERVICE,
      S_COMPLETE,
      S_HOLD
   } state_e;

   state_e                   state_q, state_d;
   logic [SRCW-1:0]          id_q, id_d;
   logic [7:0]               hold_q, hold_d;
   logic                     err_q, err_d;
   logic [15:0]              spur_cnt_q, spur_cnt_d;
   reg_intf_pkg::req_a32_d32 req_q, req_d;
   logic                     id_valid_q, id_valid_d;
   logic                     busy_q, busy_d;
   logic                     unused_rdata_hi;

   always_comb begin
      unused_rdata_hi = ^resp_i.rdata;
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      hold_d     = hold_q;
      err_d      = err_q;
      spur_cnt_d = spur_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (enable_i && eip_i) state_d = S_CLAIM;
         end
         S_CLAIM: begin
            if (resp_i.ready) begin
               if (resp_i.error) begin
                  err_d   = 1'b1;
                  state_d = S_HOLD;
               end else if (resp_i.rdata[SRCW-1:0] == '0) begin
                  if (spur_cnt_q != 16'hFFFF) spur_cnt_d = spur_cnt_q + 16'd1;
                  state_d = S_HOLD;
               end else begin
                  id_d    = resp_i.rdata[SRCW-1:0];
                  state_d = S_DELIVER;
               end
            end
         end
         S_DELIVER: begin
            if (id_ready_i) state_d = S_SERVICE;
         end
         S_SERVICE: begin
            if (done_i) state_d = S_COMPLETE;
         end
         S_COMPLETE: begin
            if (resp_i.ready) begin
               if (resp_i.error) err_d = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_q == '0) state_d = S_IDLE;
            else              hold_d  = hold_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_HOLD && state_q != S_HOLD) hold_d = 8'(HOLDOFF - 1);

      // Outputs are registered from the next state so they line up with it.
      req_d = '0;
      if (state_d == S_CLAIM) begin
         req_d.valid = 1'b1;
         req_d.addr  = CC_ADDR;
      end else if (state_d == S_COMPLETE) begin
         req_d.valid = 1'b1;
         req_d.write = 1'b1;
         req_d.addr  = CC_ADDR;
         req_d.wstrb = 4'hF;
         req_d.wdata = 32'(id_d);
      end
      id_valid_d = (state_d == S_DELIVER);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         id_q       <= '0;
         hold_q     <= '0;
         err_q      <= 1'b0;
         spur_cnt_q <= '0;
         req_q      <= '0;
         id_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         hold_q     <= hold_d;
         err_q      <= err_d;
         spur_cnt_q <= spur_cnt_d;
         req_q      <= req_d;
         id_valid_q <= id_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign req_o          = req_q;
   assign id_valid_o     = id_valid_q;
   assign id_o           = id_q;
   assign busy_o         = busy_q;
   assign bus_err_o      = err_q;
   assign spurious_cnt_o = spur_cnt_q;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Randomized bench for plic_claim_sequencer: bus slave + consumer driver, checked
// against an outcome model of each claim/complete sequence.
module tb_plic_claim_sequencer;

   localparam logic [31:0] CC      = 32'h0020_0004;
   localparam int          HOLDOFF = 4;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     enable = 1'b1;
   logic                     eip = 1'b0;
   reg_intf_pkg::req_a32_d32 req;
   reg_intf_pkg::rsp_d32     resp;
   logic                     id_valid;
   logic [4:0]               id;
   logic                     id_ready_i = 1'b0;
   logic                     done_i = 1'b0;
   logic                     busy;
   logic                     bus_err;
   logic [15:0]              spur_cnt;

   plic_claim_sequencer #(.CC_ADDR(CC), .SRCW(5), .HOLDOFF(HOLDOFF)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .eip_i(eip),
      .req_o(req), .resp_i(resp), .id_valid_o(id_valid), .id_o(id),
      .id_ready_i(id_ready_i), .done_i(done_i), .busy_o(busy),
      .bus_err_o(bus_err), .spurious_cnt_o(spur_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   // model state carried across tests
   logic [15:0] exp_spur = 16'h0;
   logic        exp_berr = 1'b0;

   // bus slave configuration and transaction log
   int          bus_wait = 0;
   bit          wr_err = 1'b0;
   logic [32:0] rd_q[$];
   int          n_rd = 0, n_wr = 0, stab_err = 0;
   int          rd_start_cyc = 0, rd_done_cyc = 0, wr_start_cyc = 0, wr_done_cyc = 0;
   reg_intf_pkg::req_a32_d32 last_r, last_w;

   initial begin
      int wc;
      bit pend;
      reg_intf_pkg::req_a32_d32 prev;
      logic [32:0] ent;
      wc = 0; pend = 0; prev = '0;
      resp = '0;
      forever begin
         @(negedge clk);
         if (rst_n && req.valid) begin
            if (!pend) begin
               pend = 1; wc = 0; prev = req;
               if (req.write) wr_start_cyc = cyc; else rd_start_cyc = cyc;
            end else if (req !== prev) stab_err++;
            if (wc < bus_wait) begin
               wc++;
               resp.ready = 1'b0; resp.error = 1'b0; resp.rdata = $urandom;
            end else begin
               resp.ready = 1'b1; pend = 0;
               if (req.write) begin
                  n_wr++; last_w = req; wr_done_cyc = cyc;
                  resp.error = wr_err; resp.rdata = $urandom;
               end else begin
                  n_rd++; last_r = req; rd_done_cyc = cyc;
                  ent = (rd_q.size() > 0) ? rd_q.pop_front() : 33'h0;
                  resp.error = ent[32]; resp.rdata = ent[31:0];
               end
            end
         end else begin
            resp = '0; pend = 0;
         end
      end
   end

   typedef struct {
      bit         delivered;
      logic [4:0] id;
      bit         unstable;
      int         done_cyc;
      int         eip_cyc;
      int         deliver_cyc;
      int         idle_cyc;
      bit         to;
   } seq_res_t;

   // Stimulus only: runs one eip -> claim -> (deliver/service/complete) -> idle pass.
   task automatic do_seq(input logic [31:0] rd, input bit err, input int rwait, input bit werr,
                         input int rdy_dly, input int done_dly, input bit stray,
                         output seq_res_t r);
      bit started, acc;
      int cnt_rdy, cnt_done;
      started = 0; acc = 0; cnt_rdy = 0; cnt_done = -1;
      rd_q.push_back({err, rd}); bus_wait = rwait; wr_err = werr;
      r.delivered = 0; r.id = '0; r.unstable = 0; r.done_cyc = -1;
      r.deliver_cyc = -1; r.idle_cyc = -1; r.to = 1;
      @(negedge clk); eip = 1'b1; r.eip_cyc = cyc;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (done_i) done_i = 1'b0;
         if (busy) begin started = 1; eip = 1'b0; end
         if (id_ready_i) begin
            id_ready_i = 1'b0; acc = 1; cnt_done = done_dly;
         end else if (id_valid) begin
            if (!r.delivered) begin
               r.delivered = 1; r.id = id; r.deliver_cyc = cyc;
               if (stray) done_i = 1'b1;
            end else if (id !== r.id) r.unstable = 1;
            if (cnt_rdy >= rdy_dly) id_ready_i = 1'b1; else cnt_rdy++;
         end
         if (acc && cnt_done == 0) begin
            done_i = 1'b1; r.done_cyc = cyc; cnt_done = -1;
         end else if (acc && cnt_done > 0) cnt_done--;
         if (started && !busy) begin r.idle_cyc = cyc; r.to = 0; break; end
      end
      eip = 1'b0; id_ready_i = 1'b0; done_i = 1'b0;
      rd_q.delete();
   endtask

   task automatic test_reset();
      #1;
      n_chk++; if (req !== '0) begin n_fail++; $display("FAIL reset_req: got %h expected 0", req); end
      n_chk++; if ({id_valid, id, busy, bus_err} !== 8'h0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", {id_valid, id, busy, bus_err}); end
      n_chk++; if (spur_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_spur: got %h expected 0", spur_cnt); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      seq_res_t r;
      int w0;
      w0 = n_wr;
      do_seq(32'd3, 0, 0, 0, 0, 1, 0, r);
      n_chk++; if (r.to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", r.to); end
      n_chk++; if (r.id !== 5'd3) begin n_fail++; $display("FAIL basic_id: got %0d expected 3", r.id); end
      n_chk++; if (n_wr - w0 !== 1) begin n_fail++; $display("FAIL basic_nwr: got %0d expected 1", n_wr - w0); end
      n_chk++; if ({last_w.addr, last_w.wdata, last_w.wstrb} !== {CC, 32'd3, 4'hF}) begin n_fail++; $display("FAIL basic_write: got %h/%h/%h expected %h/3/f", last_w.addr, last_w.wdata, last_w.wstrb, CC); end
      n_chk++; if ({last_r.addr, last_r.write, last_r.wdata, last_r.wstrb} !== {CC, 1'b0, 32'd0, 4'h0}) begin n_fail++; $display("FAIL basic_read: got %h/%b/%h/%h expected %h/0/0/0", last_r.addr, last_r.write, last_r.wdata, last_r.wstrb, CC); end
      n_chk++; if (rd_start_cyc !== r.eip_cyc + 1) begin n_fail++; $display("FAIL basic_claim_lat: got %0d expected %0d", rd_start_cyc, r.eip_cyc + 1); end
      n_chk++; if (rd_done_cyc !== rd_start_cyc) begin n_fail++; $display("FAIL basic_claim_len: got %0d expected %0d", rd_done_cyc, rd_start_cyc); end
      n_chk++; if (r.deliver_cyc !== rd_done_cyc + 1) begin n_fail++; $display("FAIL basic_deliver_lat: got %0d expected %0d", r.deliver_cyc, rd_done_cyc + 1); end
      n_chk++; if (wr_start_cyc !== r.done_cyc + 1) begin n_fail++; $display("FAIL basic_complete_lat: got %0d expected %0d", wr_start_cyc, r.done_cyc + 1); end
      n_chk++; if (r.idle_cyc !== wr_done_cyc + HOLDOFF + 1) begin n_fail++; $display("FAIL basic_holdoff: got %0d expected %0d", r.idle_cyc, wr_done_cyc + HOLDOFF + 1); end
   endtask

   task automatic test_backpressure();
      seq_res_t r;
      int w0, r0;
      w0 = n_wr; r0 = n_rd; stab_err = 0;
      do_seq(32'hFFFF_FFE5, 0, 5, 0, 1, 0, 0, r);
      n_chk++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err); end
      n_chk++; if ({n_rd - r0, n_wr - w0} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL bp_counts: got rd=%0d wr=%0d expected 1/1", n_rd - r0, n_wr - w0); end
      n_chk++; if (r.id !== 5'd5) begin n_fail++; $display("FAIL bp_id: got %0d expected 5", r.id); end
      n_chk++; if (rd_done_cyc - rd_start_cyc !== 5) begin n_fail++; $display("FAIL bp_rd_wait: got %0d expected 5", rd_done_cyc - rd_start_cyc); end
      n_chk++; if (wr_done_cyc - wr_start_cyc !== 5) begin n_fail++; $display("FAIL bp_wr_wait: got %0d expected 5", wr_done_cyc - wr_start_cyc); end
      n_chk++; if (last_w.wdata !== 32'd5) begin n_fail++; $display("FAIL bp_wdata: got %h expected 5", last_w.wdata); end
   endtask

   task automatic test_spurious();
      seq_res_t r;
      int w0;
      w0 = n_wr;
      n_chk++; if (spur_cnt !== exp_spur) begin n_fail++; $display("FAIL spur_before: got %h expected %h", spur_cnt, exp_spur); end
      do_seq(32'h0000_0FE0, 0, 0, 0, 0, 0, 0, r);
      exp_spur = exp_spur + 16'd1;
      n_chk++; if (spur_cnt !== exp_spur) begin n_fail++; $display("FAIL spur_after: got %h expected %h", spur_cnt, exp_spur); end
      n_chk++; if ({r.delivered, r.to} !== 2'b00) begin n_fail++; $display("FAIL spur_nodeliver: got del=%0d to=%0d expected 0/0", r.delivered, r.to); end
      n_chk++; if (n_wr !== w0) begin n_fail++; $display("FAIL spur_nowrite: got %0d expected %0d", n_wr, w0); end
      n_chk++; if (r.idle_cyc !== rd_done_cyc + HOLDOFF + 1) begin n_fail++; $display("FAIL spur_holdoff: got %0d expected %0d", r.idle_cyc, rd_done_cyc + HOLDOFF + 1); end
   endtask

   task automatic test_stray_done();
      seq_res_t r;
      int w0;
      w0 = n_wr;
      do_seq(32'd12, 0, 0, 0, 10, 3, 1, r);
      n_chk++; if (r.unstable !== 1'b0) begin n_fail++; $display("FAIL stall_id_stable: got unstable=%0d expected 0", r.unstable); end
      n_chk++; if (r.id !== 5'd12) begin n_fail++; $display("FAIL stall_id: got %0d expected 12", r.id); end
      n_chk++; if (wr_start_cyc !== r.done_cyc + 1) begin n_fail++; $display("FAIL stall_complete_after_done: got %0d expected %0d", wr_start_cyc, r.done_cyc + 1); end
      n_chk++; if (n_wr - w0 !== 1) begin n_fail++; $display("FAIL stall_nwr: got %0d expected 1", n_wr - w0); end
   endtask

   task automatic test_enable();
      bit saw;
      int r0;
      saw = 0; r0 = n_rd;
      @(negedge clk); enable = 1'b0; eip = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy || req.valid) saw = 1;
      end
      eip = 1'b0; enable = 1'b1;
      n_chk++; if ({saw, n_rd - r0} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL enable_off: got busy_seen=%0d reads=%0d expected 0/0", saw, n_rd - r0); end
   endtask

   task automatic test_bus_error();
      seq_res_t r;
      int w0;
      w0 = n_wr;
      do_seq(32'd7, 1, 1, 0, 0, 0, 0, r);
      exp_berr = 1'b1;
      n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL berr_set: got %b expected 1", bus_err); end
      n_chk++; if ({r.delivered, r.to, n_wr - w0} !== {1'b0, 1'b0, 32'd0}) begin n_fail++; $display("FAIL berr_nodeliver: got del=%0d to=%0d wr=%0d expected 0/0/0", r.delivered, r.to, n_wr - w0); end
      do_seq(32'd9, 0, 0, 0, 0, 0, 0, r);
      n_chk++; if ({bus_err, r.id} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL berr_sticky: got err=%b id=%0d expected 1/9", bus_err, r.id); end
   endtask

   task automatic test_random();
      seq_res_t r;
      logic [31:0] rd;
      logic [4:0]  eid;
      bit err, werr, edel;
      int w0, r0;
      for (int i = 0; i < 40; i++) begin
         rd   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom;
         err  = ($urandom_range(0, 7) == 0);
         werr = ($urandom_range(0, 7) == 0);
         eid  = rd[4:0];
         edel = !err && (eid != 5'd0);
         w0 = n_wr; r0 = n_rd;
         do_seq(rd, err, $urandom_range(0, 3), werr, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 1), r);
         if (!err && eid == 5'd0 && exp_spur != 16'hFFFF) exp_spur = exp_spur + 16'd1;
         if (err || (edel && werr)) exp_berr = 1'b1;
         n_chk++; if ({r.to, r.delivered, n_rd - r0, n_wr - w0} !== {1'b0, edel, 32'd1, 32'(edel)}) begin n_fail++; $display("FAIL rand_flow[%0d]: got to=%0d del=%0d rd=%0d wr=%0d expected 0/%0d/1/%0d", i, r.to, r.delivered, n_rd - r0, n_wr - w0, edel, edel); end
         if (edel) begin
            n_chk++; if ({r.id, last_w.wdata, r.unstable} !== {eid, 32'(eid), 1'b0}) begin n_fail++; $display("FAIL rand_id[%0d]: got id=%0d wdata=%h unstable=%0d expected %0d", i, r.id, last_w.wdata, r.unstable, eid); end
            n_chk++; if (wr_start_cyc !== r.done_cyc + 1) begin n_fail++; $display("FAIL rand_complete_lat[%0d]: got %0d expected %0d", i, wr_start_cyc, r.done_cyc + 1); end
         end
         n_chk++; if ({spur_cnt, bus_err} !== {exp_spur, exp_berr}) begin n_fail++; $display("FAIL rand_status[%0d]: got spur=%h err=%b expected %h/%b", i, spur_cnt, bus_err, exp_spur, exp_berr); end
      end
      wr_err = 1'b0;
   endtask

   task automatic test_saturation();
      seq_res_t r;
      @(negedge clk);
      force dut.spur_cnt_q = 16'hFFFE;
      #1 release dut.spur_cnt_q;
      do_seq(32'd0, 0, 0, 0, 0, 0, 0, r);
      n_chk++; if (spur_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", spur_cnt); end
      do_seq(32'h20, 0, 0, 0, 0, 0, 0, r);
      n_chk++; if (spur_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", spur_cnt); end
   endtask

   task automatic test_reset_mid();
      int w0;
      bit got;
      w0 = n_wr; got = 0;
      rd_q.push_back({1'b0, 32'd9}); bus_wait = 0;
      @(negedge clk); eip = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (busy) eip = 1'b0;
         if (id_valid) begin id_ready_i = 1'b1; got = 1; end
      end
      @(negedge clk); id_ready_i = 1'b0; eip = 1'b0;
      @(negedge clk);
      n_chk++; if ({got, busy, id_valid, req.valid} !== 4'b1100) begin n_fail++; $display("FAIL rstmid_in_service: got %b expected 1100", {got, busy, id_valid, req.valid}); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (req !== '0) begin n_fail++; $display("FAIL rstmid_req: got %h expected 0", req); end
      n_chk++; if ({id_valid, id, busy, bus_err, spur_cnt} !== 24'h0) begin n_fail++; $display("FAIL rstmid_outs: got %h expected 0", {id_valid, id, busy, bus_err, spur_cnt}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); done_i = 1'b1;
      @(negedge clk); done_i = 1'b0;
      repeat (10) @(negedge clk);
      n_chk++; if ({n_wr - w0, 31'd0, busy} !== 64'd0) begin n_fail++; $display("FAIL rstmid_nowrite: got wr=%0d busy=%b expected 0/0", n_wr - w0, busy); end
      rd_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_spurious();
      test_stray_done();
      test_enable();
      test_bus_error();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
